// File: rtl/tespar_feature_serializer.sv
// -----------------------------------------------------------------------------
// tespar_feature_serializer
//   Reader side of the tespar feature-vector interface. On each end-of-window
//   pulse it snapshots the flat histogram produced by tespar. It then streams
//   the bins out, one per beat, over a valid/ready interface. Because the
//   stream reads the snapshot and not the live counters, tespar can start its
//   next window at once.
//
// Ports
//   clk             in   rising-edge system clock
//   reset           in   synchronous, active-high reset
//   frame_done      in   1-cycle pulse: feature_vector valid, window closed
//   feature_vector  in   ALPHA_COUNT*COUNT_WIDTH flat bins, bin k at [k*W +: W]
//   m_ready         in   consumer accepts the current beat
//   m_valid         out  beat available
//   m_data          out  count of the current bin
//   m_index         out  number of the current bin, 0..ALPHA_COUNT-1
//   m_last          out  high with bin ALPHA_COUNT-1
//   busy            out  high while a frame is being streamed
//   overrun         out  sticky: a frame_done arrived while busy and was dropped
//   frame_count     out  completed frames, wraps at 65535 -> 0
// -----------------------------------------------------------------------------
module tespar_feature_serializer #(
    parameter int unsigned ALPHA_COUNT = 8,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned IDX_WIDTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frame_done,
    input  logic [ALPHA_COUNT*COUNT_WIDTH-1:0] feature_vector,
    input  logic                               m_ready,
    output logic                               m_valid,
    output logic [COUNT_WIDTH-1:0]             m_data,
    output logic [IDX_WIDTH-1:0]               m_index,
    output logic                               m_last,
    output logic                               busy,
    output logic                               overrun,
    output logic [15:0]                        frame_count
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(ALPHA_COUNT - 1);
    localparam logic                 FIRST_IS_LAST = (ALPHA_COUNT == 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] snap [ALPHA_COUNT];

    // Index and bin count of the beat that follows the current one.
    logic [IDX_WIDTH-1:0]   next_idx_c;
    logic [COUNT_WIDTH-1:0] next_bin_c;
    logic [COUNT_WIDTH-1:0] first_bin_c;
    logic                   beat_xfer_c;
    logic                   last_xfer_c;

    assign next_idx_c  = m_index + IDX_WIDTH'(1);
    assign first_bin_c = feature_vector[COUNT_WIDTH-1:0];
    assign beat_xfer_c = m_valid & m_ready;
    assign last_xfer_c = beat_xfer_c & m_last;

    // Select the snapshot bin for the next beat.
    always_comb begin
        next_bin_c = '0;
        for (int k = 0; k < int'(ALPHA_COUNT); k++) begin
            if (next_idx_c == IDX_WIDTH'(k)) begin
                next_bin_c = snap[k];
            end
        end
    end

    // Control FSM with registered stream outputs and the snapshot store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_index     <= '0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
            for (int k = 0; k < int'(ALPHA_COUNT); k++) begin
                snap[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_done) begin
                        for (int k = 0; k < int'(ALPHA_COUNT); k++) begin
                            snap[k] <= feature_vector[k*COUNT_WIDTH +: COUNT_WIDTH];
                        end
                        state   <= SEND;
                        busy    <= 1'b1;
                        m_valid <= 1'b1;
                        m_index <= '0;
                        m_data  <= first_bin_c;
                        m_last  <= FIRST_IS_LAST;
                    end
                end

                SEND: begin
                    if (last_xfer_c) begin
                        frame_count <= frame_count + 16'd1;
                        if (frame_done) begin
                            // Back-to-back frame: the window closed exactly as
                            // the previous stream finished, so nothing is lost.
                            for (int k = 0; k < int'(ALPHA_COUNT); k++) begin
                                snap[k] <= feature_vector[k*COUNT_WIDTH +: COUNT_WIDTH];
                            end
                            m_index <= '0;
                            m_data  <= first_bin_c;
                            m_last  <= FIRST_IS_LAST;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            m_valid <= 1'b0;
                            m_index <= '0;
                            m_data  <= '0;
                            m_last  <= 1'b0;
                        end
                    end else begin
                        if (beat_xfer_c) begin
                            m_index <= next_idx_c;
                            m_data  <= next_bin_c;
                            m_last  <= (next_idx_c == LAST_IDX);
                        end
                        // A window closing mid-stream cannot be captured.
                        if (frame_done) begin
                            overrun <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tespar_feature_serializer.sv
// -----------------------------------------------------------------------------
// tb_tespar_feature_serializer
//   Directed bench for tespar_feature_serializer. Inputs change just after the
//   falling edge; outputs are sampled on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_tespar_feature_serializer;

    localparam int unsigned ALPHA_COUNT = 8;
    localparam int unsigned COUNT_WIDTH = 16;
    localparam int unsigned IDX_WIDTH   = 4;

    logic                               clk;
    logic                               reset;
    logic                               frame_done;
    logic [ALPHA_COUNT*COUNT_WIDTH-1:0] feature_vector;
    logic                               m_ready;
    logic                               m_valid;
    logic [COUNT_WIDTH-1:0]             m_data;
    logic [IDX_WIDTH-1:0]               m_index;
    logic                               m_last;
    logic                               busy;
    logic                               overrun;
    logic [15:0]                        frame_count;

    int checks;
    int errors;
    int xfers;

    tespar_feature_serializer #(
        .ALPHA_COUNT (ALPHA_COUNT),
        .COUNT_WIDTH (COUNT_WIDTH),
        .IDX_WIDTH   (IDX_WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_done     (frame_done),
        .feature_vector (feature_vector),
        .m_ready        (m_ready),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_index        (m_index),
        .m_last         (m_last),
        .busy           (busy),
        .overrun        (overrun),
        .frame_count    (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bin k = base + step*k.
    task automatic set_fv(input int base, input int step);
        for (int k = 0; k < int'(ALPHA_COUNT); k++) begin
            feature_vector[k*COUNT_WIDTH +: COUNT_WIDTH] = COUNT_WIDTH'(base + step*k);
        end
    endtask

    task automatic chk_beat(input string tag, input int k, input int data);
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_data"},  32'(m_data),  32'(data));
        chk({tag, "_index"}, 32'(m_index), 32'(k));
        chk({tag, "_last"},  32'(m_last),  32'(k == 7));
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        frame_done = 1'b0;
        m_ready    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        frame_done     = 1'b0;
        m_ready        = 1'b0;
        feature_vector = '0;
        @(negedge clk);

        // 1: reset for two clocks, everything zero, stays idle without frame_done
        tick();
        tick();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data",  32'(m_data),  32'd0);
        chk("rst_index", 32'(m_index), 32'd0);
        chk("rst_last",  32'(m_last),  32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_ovr",   32'(overrun), 32'd0);
        chk("rst_fcnt",  32'(frame_count), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("idle_valid", 32'(m_valid), 32'd0);

        // 2: full-rate stream of {1,11,...,71}
        set_fv(1, 10);
        m_ready    = 1'b1;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk_beat("t2", k, 1 + 10*k);
            tick();
        end
        chk("t2_end_valid", 32'(m_valid), 32'd0);
        chk("t2_end_busy",  32'(busy),    32'd0);
        chk("t2_fcnt",      32'(frame_count), 32'd1);

        // 3: alternating ready, input vector trashed after capture
        do_reset();
        set_fv(1, 10);
        frame_done = 1'b1;
        tick();
        frame_done     = 1'b0;
        feature_vector = {ALPHA_COUNT{16'hFFFF}};
        xfers = 0;
        for (int k = 0; k < 8; k++) begin
            m_ready = 1'b0;
            chk_beat("t3_hold", k, 1 + 10*k);
            tick();
            m_ready = 1'b1;
            chk_beat("t3_xfer", k, 1 + 10*k);
            if (m_valid && m_ready) xfers++;
            tick();
        end
        m_ready = 1'b0;
        chk("t3_xfers",     32'(xfers),   32'd8);
        chk("t3_end_valid", 32'(m_valid), 32'd0);
        chk("t3_fcnt",      32'(frame_count), 32'd1);

        // 4: frame_done mid-stream is dropped and flags overrun
        do_reset();
        set_fv(1, 10);
        m_ready    = 1'b1;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                frame_done = 1'b1;
                set_fv(16'h0AAA, 0);
            end else begin
                frame_done = 1'b0;
            end
            chk_beat("t4", k, 1 + 10*k);
            tick();
            if (k == 3) chk("t4_ovr_set", 32'(overrun), 32'd1);
        end
        frame_done = 1'b0;
        chk("t4_end_valid", 32'(m_valid), 32'd0);
        chk("t4_ovr_sticky", 32'(overrun), 32'd1);
        chk("t4_fcnt",      32'(frame_count), 32'd1);

        // 5: second frame captured on the last handshake of the first
        do_reset();
        set_fv(1, 10);
        m_ready    = 1'b1;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                set_fv(100, 1);
                frame_done = 1'b1;
            end
            chk_beat("t5a", k, 1 + 10*k);
            tick();
        end
        frame_done = 1'b0;
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_fcnt_mid", 32'(frame_count), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk_beat("t5b", k, 100 + k);
            tick();
        end
        chk("t5_end_valid", 32'(m_valid), 32'd0);
        chk("t5_ovr",       32'(overrun), 32'd0);
        chk("t5_fcnt",      32'(frame_count), 32'd2);

        // 6: reset mid-frame abandons the stream, then a clean frame follows
        set_fv(1, 10);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat("t6a", k, 1 + 10*k);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_index", 32'(m_index), 32'd0);
        chk("t6_rst_fcnt",  32'(frame_count), 32'd0);
        chk("t6_rst_ovr",   32'(overrun), 32'd0);
        chk("t6_rst_busy",  32'(busy),    32'd0);
        set_fv(500, 3);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_beat("t6b", k, 500 + 3*k);
            tick();
        end
        chk("t6_end_valid", 32'(m_valid), 32'd0);
        chk("t6_fcnt",      32'(frame_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
